// File: rtl/ntt_result_streamer_if.sv
// Output stream bundle of the NTT result streamer: data word, index, last flag,
// modulus index and the valid/ready handshake.
interface ntt_result_streamer_if #(
   parameter int unsigned W     = 32,
   parameter int unsigned IDX_W = 9
);
   logic [W-1:0]     m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;
   logic [IDX_W-1:0] m_idx;
   logic [5:0]       m_mod_idx;

   modport master (
      output m_data, m_valid, m_last, m_idx, m_mod_idx,
      input  m_ready
   );

   modport slave (
      input  m_data, m_valid, m_last, m_idx, m_mod_idx,
      output m_ready
   );
endinterface

// File: rtl/ntt_result_streamer.sv
// Captures the NTT core's parallel N-coefficient result on done_in and streams it
// one word per transfer over valid/ready, flagging results dropped while busy.
module ntt_result_streamer #(
   parameter int unsigned N     = 257,
   parameter int unsigned W     = 32,
   parameter int unsigned IDX_W = 9
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 done_in,
   input  logic [N*W-1:0]       data_in,
   input  logic [5:0]           mod_idx_in,
   ntt_result_streamer_if.master m,
   output logic                 busy,
   output logic                 overrun,
   input  logic                 clr_overrun
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] idx;
   logic [W-1:0]     buf_q [N];
   logic [5:0]       mod_q;
   logic             xfer, final_xfer, capture, drop;

   assign xfer       = (state == STREAM) && m.m_ready;
   assign final_xfer = xfer && (idx == LAST);
   // A new result is only taken when idle or when the last word leaves this cycle.
   assign capture    = done_in && ((state == IDLE) || final_xfer);
   assign drop       = done_in && !capture;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (done_in) state_next = STREAM;
         STREAM:  if (final_xfer && !done_in) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      m.m_valid   = (state == STREAM);
      busy        = (state == STREAM);
      m.m_idx     = (state == STREAM) ? idx : '0;
      m.m_last    = (state == STREAM) && (idx == LAST);
      m.m_data    = (state == STREAM) ? buf_q[idx] : '0;
      m.m_mod_idx = mod_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         mod_q   <= '0;
         overrun <= 1'b0;
      end else begin
         if (capture) begin
            idx   <= '0;
            mod_q <= mod_idx_in;
         end else if (xfer) begin
            idx <= (idx == LAST) ? '0 : idx + IDX_W'(1);
         end
         if (drop)             overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         for (int unsigned i = 0; i < N; i++) buf_q[i] <= data_in[W*i +: W];
      end
   end

   idx_in_range: assert property (@(posedge clk) disable iff (reset) idx <= LAST);

endmodule

// File: tb/tb_ntt_result_streamer.sv
// Random and directed stimulus for ntt_result_streamer; a word-count reference model
// fills a scoreboard queue that a negedge monitor drains on every transfer.
module tb_ntt_result_streamer;
   localparam int unsigned N     = 257;
   localparam int unsigned W     = 32;
   localparam int unsigned IDX_W = 9;

   typedef struct {
      logic [W-1:0]     data;
      logic [IDX_W-1:0] idx;
      logic             last;
      logic [5:0]       mod;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           done_in = 1'b0;
   logic [N*W-1:0] data_in = '0;
   logic [5:0]     mod_idx_in = '0;
   logic           clr_overrun = 1'b0;
   logic           busy, overrun;

   ntt_result_streamer_if #(.W(W), .IDX_W(IDX_W)) sif ();

   ntt_result_streamer #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .done_in     (done_in),
      .data_in     (data_in),
      .mod_idx_in  (mod_idx_in),
      .m           (sif.master),
      .busy        (busy),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];
   int   rem = 0, rem_pre = 0;       // words still owed by the model, after / before this cycle
   logic ovr = 1'b0, ovr_pre = 1'b0;
   logic prev_stall = 1'b0;
   exp_t held;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus, applied just after the rising edge, plus the model update.
   task automatic step(input logic d, input logic r, input logic c, input logic pat,
                       input logic [5:0] mod);
      logic accept;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
         data_in[W*i +: W] = pat ? 32'hA000_0000 + 32'(i) : $urandom;
      done_in     = d;
      sif.m_ready = r;
      clr_overrun = c;
      mod_idx_in  = mod;
      rem_pre = rem;
      ovr_pre = ovr;
      accept  = d && (rem == 0 || (rem == 1 && r));
      if (accept) begin
         for (int i = 0; i < N; i++) begin
            exp_t e;
            e.data = data_in[W*i +: W];
            e.idx  = IDX_W'(i);
            e.last = (i == N - 1);
            e.mod  = mod;
            sb.push_back(e);
         end
         rem = N;
      end else if (rem > 0 && r) begin
         rem--;
      end
      if (d && !accept) ovr = 1'b1;
      else if (c)       ovr = 1'b0;
   endtask

   task automatic rstep(input logic d, input logic r, input logic c);
      step(d, r, c, 1'b0, 6'($urandom));
   endtask

   task automatic drain();
      int n = 0;
      while (rem != 0 && n < 3000) begin
         rstep(1'b0, 1'b1, 1'b0);
         n++;
      end
      check("drain_timeout", 64'(rem), 64'd0);
   endtask

   task automatic async_reset();
      reset   = 1'b1;
      done_in = 1'b0;
      #1;
      check("rst_valid", 64'(sif.m_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_idx", 64'(sif.m_idx), 64'd0);
      check("rst_data", 64'(sif.m_data), 64'd0);
      check("rst_last", 64'(sif.m_last), 64'd0);
      check("rst_mod", 64'(sif.m_mod_idx), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      sb.delete();
      rem = 0; rem_pre = 0; ovr = 1'b0; ovr_pre = 1'b0; prev_stall = 1'b0;
      @(negedge clk); #1;
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check("valid", 64'(sif.m_valid), 64'(rem_pre != 0));
         check("busy", 64'(busy), 64'(rem_pre != 0));
         check("overrun", 64'(overrun), 64'(ovr_pre));
         if (prev_stall) begin
            check("stall_data", 64'(sif.m_data), 64'(held.data));
            check("stall_idx", 64'(sif.m_idx), 64'(held.idx));
            check("stall_last", 64'(sif.m_last), 64'(held.last));
            check("stall_mod", 64'(sif.m_mod_idx), 64'(held.mod));
         end
         if (sif.m_valid && sif.m_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_word", 64'(sif.m_idx), 64'h1FF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("word_data", 64'(sif.m_data), 64'(e.data));
               check("word_idx", 64'(sif.m_idx), 64'(e.idx));
               check("word_last", 64'(sif.m_last), 64'(e.last));
               check("word_mod", 64'(sif.m_mod_idx), 64'(e.mod));
            end
         end
         prev_stall     = sif.m_valid && !sif.m_ready;
         held.data      = sif.m_data;
         held.idx       = sif.m_idx;
         held.last      = sif.m_last;
         held.mod       = sif.m_mod_idx;
      end
   end

   initial begin
      sif.m_ready = 1'b0;
      #1;
      check("init_valid", 64'(sif.m_valid), 64'd0);
      check("init_busy", 64'(busy), 64'd0);
      check("init_overrun", 64'(overrun), 64'd0);
      check("init_idx", 64'(sif.m_idx), 64'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Full-throughput stream of the pattern result, modulus 37, mod_idx_in wandering.
      step(1'b1, 1'b1, 1'b0, 1'b1, 6'd37);
      drain();
      repeat (3) rstep(1'b0, 1'b1, 1'b0);

      // Stall pattern 1,0,0,1 on the same data.
      step(1'b1, 1'b1, 1'b0, 1'b1, 6'd5);
      for (int k = 0; k < 1200 && rem != 0; k++)
         rstep(1'b0, (k % 4 == 0) || (k % 4 == 3), 1'b0);
      check("stall_run_done", 64'(rem), 64'd0);

      // Dropped result mid-stream, then clear.
      rstep(1'b1, 1'b1, 1'b0);
      repeat (99) rstep(1'b0, 1'b1, 1'b0);
      rstep(1'b1, 1'b1, 1'b0);
      repeat (5) rstep(1'b0, 1'b1, 1'b0);
      rstep(1'b0, 1'b1, 1'b1);
      drain();
      rstep(1'b0, 1'b0, 1'b0);

      // Back-to-back capture on the final transfer.
      rstep(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 400 && rem != 1; k++) rstep(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 6'd42);
      drain();

      // Reset in the middle of a stream, then restart.
      rstep(1'b1, 1'b1, 1'b0);
      repeat (50) rstep(1'b0, 1'b1, 1'b0);
      async_reset();
      rstep(1'b1, 1'b1, 1'b0);
      drain();

      // Random traffic.
      for (int k = 0; k < 4000; k++) begin
         logic r, d;
         r = ($urandom_range(0, 3) != 0);
         d = ($urandom_range(0, 199) < 3) || (rem == 1 && r && $urandom_range(0, 1) == 1);
         rstep(d, r, ($urandom_range(0, 59) == 0));
      end
      drain();
      repeat (2) rstep(1'b0, 1'b1, 1'b0);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
